// File: rtl/frame_history_writer.sv
// Read-modify-write producer for the 9-bit, three-frame history buffer.
// Build option FHW_FIRST_FILL_EN: first frame after reset fills all chunks.
module frame_history_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [2:0]        pix_data,
  input  logic              pix_sof,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [8:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [8:0]        mem_wdata,
  output logic [1:0]        frame_chunk_counter,
  output logic              frame_done,
  output logic              frame_drop
);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(H_RES * V_RES - 1);
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0]        state;
  logic [1:0]        wait_cnt;
  logic [1:0]        wr_chunk;
  logic [2:0]        lat_pix;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] lat_addr;
  logic [ADDR_W-1:0] acc_addr;
  logic              accept;
`ifdef FHW_FIRST_FILL_EN
  logic              first_fill;
`endif

  assign accept   = (state == IDLE) && pix_ready && pix_valid;
  assign acc_addr = pix_sof ? '0 : pix_addr;

  // Chunk 0 is the top three bits, chunk 2 the bottom three.
  function automatic logic [8:0] merge(
    input logic [8:0] word,
    input logic [1:0] chunk,
    input logic [2:0] pix
  );
    logic [8:0] r;
    r = word;
    case (chunk)
      2'd0:    r[8:6] = pix;
      2'd1:    r[5:3] = pix;
      default: r[2:0] = pix;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      wait_cnt            <= '0;
      wr_chunk            <= '0;
      lat_pix             <= '0;
      pix_addr            <= '0;
      lat_addr            <= '0;
      pix_ready           <= 1'b0;
      mem_addr            <= '0;
      mem_rd_en           <= 1'b0;
      mem_wr_en           <= 1'b0;
      mem_wdata           <= '0;
      frame_chunk_counter <= '0;
      frame_done          <= 1'b0;
      frame_drop          <= 1'b0;
`ifdef FHW_FIRST_FILL_EN
      first_fill          <= 1'b1;
`endif
    end else begin
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            lat_pix    <= pix_data;
            lat_addr   <= acc_addr;
            mem_addr   <= acc_addr;
            pix_ready  <= 1'b0;
            frame_drop <= pix_sof && (pix_addr != '0);
`ifdef FHW_FIRST_FILL_EN
            if (first_fill) begin
              state     <= WRITE;
              mem_wr_en <= 1'b1;
              mem_wdata <= {3{pix_data}};
            end else begin
              state     <= READ;
              mem_rd_en <= 1'b1;
            end
`else
            state     <= READ;
            mem_rd_en <= 1'b1;
`endif
          end else begin
            pix_ready <= 1'b1;
          end
        end
        READ: begin
          mem_rd_en <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state     <= WRITE;
            mem_wr_en <= 1'b1;
            mem_wdata <= merge(mem_rdata, wr_chunk, lat_pix);
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        WRITE: begin
          mem_wr_en <= 1'b0;
          pix_ready <= 1'b1;
          state     <= IDLE;
          if (lat_addr == LAST_ADDR) begin
            pix_addr            <= '0;
            frame_chunk_counter <= wr_chunk;
            wr_chunk   <= (wr_chunk == 2'd2) ? 2'd0 : wr_chunk + 2'd1;
            frame_done <= 1'b1;
`ifdef FHW_FIRST_FILL_EN
            first_fill <= 1'b0;
`endif
          end else begin
            pix_addr <= lat_addr + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_history_writer.sv
// Randomized bench for frame_history_writer on a 4x2 frame.
// Reference model tracks the history buffer word by word.
module tb_frame_history_writer;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 3;
  localparam int RL = 1;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic [2:0]    pix_data = '0;
  logic          pix_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [8:0]    mem_rdata = '0;
  logic          mem_wr_en;
  logic [8:0]    mem_wdata;
  logic [1:0]    fcc;
  logic          frame_done;
  logic          frame_drop;

  always #5 clk = ~clk;

  frame_history_writer #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .RD_LAT(RL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .pix_sof(pix_sof),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .frame_chunk_counter(fcc),
    .frame_done(frame_done),
    .frame_drop(frame_drop)
  );

  logic [8:0] mem [NPIX];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd_en ? mem[mem_addr] : 9'h000;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] ref_mem [NPIX];
  int ref_pos, ref_chunk, ref_fcc;
  bit ref_ff;

  int e_addr, e_done, e_drop, e_rd, e_cyc;
  logic [8:0] e_wdata;

  int o_rd, o_wr, o_done, o_drop, o_cyc, o_rd_addr, o_wr_addr;
  logic [8:0] o_wdata;
  bit o_timeout;

  function automatic void model_reset();
    ref_pos = 0;
    ref_chunk = 0;
    ref_fcc = 0;
`ifdef FHW_FIRST_FILL_EN
    ref_ff = 1'b1;
`else
    ref_ff = 1'b0;
`endif
  endfunction

  function automatic void model_pixel(input logic [2:0] p, input bit sof);
    int sh;
    logic [8:0] m;
    e_addr = sof ? 0 : ref_pos;
    e_drop = (sof && ref_pos != 0) ? 1 : 0;
    sh = 6 - 3 * ref_chunk;
    if (ref_ff) begin
      e_wdata = {p, p, p};
    end else begin
      m = 9'(9'h007 << sh);
      e_wdata = (ref_mem[e_addr] & ~m) | 9'({6'd0, p} << sh);
    end
    e_rd = ref_ff ? 0 : 1;
    e_cyc = ref_ff ? 2 : 3 + RL;
    ref_mem[e_addr] = e_wdata;
    e_done = 0;
    if (e_addr == NPIX - 1) begin
      e_done = 1;
      ref_fcc = ref_chunk;
      ref_chunk = (ref_chunk + 1) % 3;
      ref_ff = 1'b0;
      ref_pos = 0;
    end else begin
      ref_pos = e_addr + 1;
    end
  endfunction

  // Call at a falling edge; returns at the falling edge where ready is back.
  task automatic send_pixel(input logic [2:0] p, input bit sof);
    int n;
    n = 0;
    while (pix_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    pix_valid = 1'b1;
    pix_data = p;
    pix_sof = sof;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    o_rd = 0; o_wr = 0; o_done = 0; o_drop = 0; o_cyc = 0;
    o_rd_addr = -1; o_wr_addr = -1; o_wdata = 'x;
    o_timeout = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      o_cyc++;
      if (mem_rd_en) begin o_rd++; o_rd_addr = int'(mem_addr); end
      if (mem_wr_en) begin
        o_wr++;
        o_wr_addr = int'(mem_addr);
        o_wdata = mem_wdata;
      end
      if (frame_done) o_done++;
      if (frame_drop) o_drop++;
      if (pix_ready) begin o_timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({pix_ready, mem_rd_en, mem_wr_en, frame_done, frame_drop} !== 5'b0
        || mem_addr !== '0 || mem_wdata !== '0 || fcc !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b rd=%b wr=%b addr=%0d wd=%h fcc=%0d",
               pix_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, fcc);
    end
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_cmp++;
    if (pix_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %b want 1", pix_ready);
    end
  endtask

  task automatic test_first_pixel();
    logic [8:0] want;
`ifdef FHW_FIRST_FILL_EN
    want = 9'b011_011_011;
    model_pixel(3'd3, 1'b1);
    send_pixel(3'd3, 1'b1);
`else
    want = 9'b101_111_111;
    model_pixel(3'd5, 1'b1);
    send_pixel(3'd5, 1'b1);
`endif
    n_cmp++;
    if (o_wr !== 1 || o_wr_addr !== 0 || o_wdata !== want) begin
      n_bad++;
      $display("FAIL first_write: n=%0d addr=%0d data=%b want addr 0 data %b",
               o_wr, o_wr_addr, o_wdata, want);
    end
    n_cmp++;
    if (o_rd !== e_rd || (e_rd == 1 && o_rd_addr !== 0)) begin
      n_bad++;
      $display("FAIL first_read: n=%0d addr=%0d want n=%0d addr 0",
               o_rd, o_rd_addr, e_rd);
    end
    n_cmp++;
    if (o_timeout || o_cyc !== e_cyc) begin
      n_bad++;
      $display("FAIL first_cycles: got %0d want %0d", o_cyc, e_cyc);
    end
    n_cmp++;
    if (o_done !== 0 || o_drop !== 0) begin
      n_bad++;
      $display("FAIL first_pulses: done=%0d drop=%0d want 0 0",
               o_done, o_drop);
    end
  endtask

  task automatic test_frames();
    logic [2:0] p;
    bit sof;
    for (int f = 0; f < 4; f++) begin
      for (int k = (f == 0) ? 1 : 0; k < NPIX; k++) begin
        p = (f == 1 && k == 0) ? 3'd2 : 3'($urandom_range(0, 7));
        sof = (k == 0);
        model_pixel(p, sof);
        send_pixel(p, sof);
        n_cmp++;
        if (o_wr !== 1 || o_wr_addr !== e_addr || o_wdata !== e_wdata) begin
          n_bad++;
          $display("FAIL frame_write f%0d k%0d: addr=%0d data=%b want %0d %b",
                   f, k, o_wr_addr, o_wdata, e_addr, e_wdata);
        end
        n_cmp++;
        if (o_done !== e_done || o_rd !== e_rd || o_drop !== 0) begin
          n_bad++;
          $display("FAIL frame_ctl f%0d k%0d: done=%0d rd=%0d drop=%0d want %0d %0d 0",
                   f, k, o_done, o_rd, o_drop, e_done, e_rd);
        end
        n_cmp++;
        if (o_timeout || o_cyc !== e_cyc || fcc !== 2'(ref_fcc)) begin
          n_bad++;
          $display("FAIL frame_timing f%0d k%0d: cyc=%0d fcc=%0d want %0d %0d",
                   f, k, o_cyc, fcc, e_cyc, ref_fcc);
        end
`ifndef FHW_FIRST_FILL_EN
        if (f == 1 && k == 0) begin
          n_cmp++;
          if (o_wdata !== 9'b101_010_111) begin
            n_bad++;
            $display("FAIL second_frame_word: got %b want 101010111", o_wdata);
          end
        end
`endif
      end
    end
  endtask

  task automatic test_early_sof();
    logic [2:0] p;
    int fcc_before;
    fcc_before = ref_fcc;
    for (int k = 0; k < 5 + NPIX; k++) begin
      p = 3'($urandom_range(0, 7));
      model_pixel(p, k == 0 || k == 5);
      send_pixel(p, k == 0 || k == 5);
      n_cmp++;
      if (o_wr_addr !== e_addr || o_wdata !== e_wdata
          || o_drop !== e_drop || o_done !== e_done) begin
        n_bad++;
        $display("FAIL early_sof k%0d: addr=%0d data=%b drop=%0d done=%0d want %0d %b %0d %0d",
                 k, o_wr_addr, o_wdata, o_drop, o_done,
                 e_addr, e_wdata, e_drop, e_done);
      end
      if (k == 5) begin
        n_cmp++;
        if (fcc !== 2'(fcc_before)) begin
          n_bad++;
          $display("FAIL drop_fcc: got %0d want %0d", fcc, fcc_before);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] p;
    int bad_wr;
    while (pix_ready !== 1'b1) @(negedge clk);
    pix_valid = 1'b1;
    pix_data = 3'd6;
    pix_sof = 1'b1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({pix_ready, mem_rd_en, mem_wr_en, frame_done, frame_drop} !== 5'b0
        || mem_addr !== '0 || mem_wdata !== '0 || fcc !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: rdy=%b rd=%b wr=%b addr=%0d wd=%h fcc=%0d",
               pix_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, fcc);
    end
    bad_wr = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_wr_en !== 1'b0) bad_wr++;
    end
    n_cmp++;
    if (bad_wr != 0 || mem[0] !== ref_mem[0]) begin
      n_bad++;
      $display("FAIL mid_reset_write: strobes=%0d mem0=%b want 0 %b",
               bad_wr, mem[0], ref_mem[0]);
    end
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < NPIX; k++) begin
      p = 3'($urandom_range(0, 7));
      model_pixel(p, k == 0);
      send_pixel(p, k == 0);
      n_cmp++;
      if (o_wr_addr !== e_addr || o_wdata !== e_wdata
          || o_rd !== e_rd || o_done !== e_done || o_cyc !== e_cyc) begin
        n_bad++;
        $display("FAIL post_reset k%0d: addr=%0d data=%b rd=%0d done=%0d cyc=%0d want %0d %b %0d %0d %0d",
                 k, o_wr_addr, o_wdata, o_rd, o_done, o_cyc,
                 e_addr, e_wdata, e_rd, e_done, e_cyc);
      end
    end
    n_cmp++;
    if (fcc !== 2'd0) begin
      n_bad++;
      $display("FAIL post_reset_fcc: got %0d want 0", fcc);
    end
  endtask

  task automatic test_memory();
    @(negedge clk);
    for (int a = 0; a < NPIX; a++) begin
      n_cmp++;
      if (mem[a] !== ref_mem[a]) begin
        n_bad++;
        $display("FAIL mem_word %0d: got %b want %b", a, mem[a], ref_mem[a]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < NPIX; a++) begin
      mem[a] = 9'h1FF;
      ref_mem[a] = 9'h1FF;
    end
    model_reset();
    test_reset();
    test_first_pixel();
    test_frames();
    test_early_sof();
    test_reset_mid();
    test_memory();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_history_writer.md
Name: frame_history_writer

Overview:
- Upstream producer for the temporal motion filter's 9-bit history buffer.
- Accepts a raster stream of 3-bit pixel intensities.
- For each pixel it performs a read-modify-write on the frame-buffer word at that pixel's address, replacing only the 3-bit chunk that belongs to the frame being written.
- It owns chunk rotation and publishes frame_chunk_counter, the chunk index of the most recently completed frame, to the display/filter path.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- RD_LAT, 1, frame-buffer read latency in cycles (1..3)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pix_valid  in  1  pixel present on pix_data
- pix_ready  out  1  block can accept a pixel this cycle
- pix_data  in  3  pixel intensity
- pix_sof  in  1  qualifies pix_data as first pixel of a frame
- mem_addr  out  ADDR_W  frame-buffer address
- mem_rd_en  out  1  read strobe
- mem_rdata  in  9  read data, valid RD_LAT cycles after the mem_rd_en cycle
- mem_wr_en  out  1  write strobe
- mem_wdata  out  9  write data
- frame_chunk_counter  out  2  chunk holding last completed frame: 0=[8:6], 1=[5:3], 2=[2:0]
- frame_done  out  1  one-cycle pulse when a frame completes
- frame_drop  out  1  one-cycle pulse when a frame is aborted by an early sof

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, pixel address=0, wr_chunk=0, frame_chunk_counter=0.
- Outputs held low during reset: pix_ready, mem_rd_en, mem_wr_en, frame_done, frame_drop; mem_addr=0, mem_wdata=0.
- FSM states: IDLE -> READ -> WAIT -> WRITE -> IDLE.
- IDLE: pix_ready=1 (registered, first cycle after reset release). On pix_valid: latch pix_data and address; go to READ.
  - If pix_sof=1 on accept, latched address is 0.
  - If pix_sof=1 and the internal address is nonzero, also pulse frame_drop next cycle and leave wr_chunk unchanged.
- READ: mem_rd_en=1, mem_addr=latched address; 1 cycle.
- WAIT: RD_LAT cycles; mem_rdata is sampled on the last WAIT cycle.
- WRITE: mem_wr_en=1, mem_addr=latched address; 1 cycle.
  - mem_wdata = sampled mem_rdata with chunk wr_chunk replaced by the latched pixel; the other 6 bits pass through unchanged.
- pix_ready=0 in every state except IDLE. Throughput is one pixel per 3+RD_LAT cycles.
- Address increments on each WRITE.
  - At address H_RES*V_RES-1 the WRITE wraps the address to 0.
  - frame_chunk_counter <= wr_chunk.
  - wr_chunk <= (wr_chunk==2) ? 0 : wr_chunk+1. The value 3 is never reached.
  - frame_done pulses in the following cycle.
- frame_chunk_counter changes only at frame completion, never mid-frame.
- Mid-operation reset: the FSM aborts immediately and no write strobe is issued after assertion. The partial frame is discarded.

Optional Feature:
- Macro: FHW_FIRST_FILL_EN.
- Defined: for the first complete frame after reset, READ/WAIT are skipped (IDLE -> WRITE). mem_wdata = {p,p,p}, so history is self-consistent and the filter reports zero motion instead of garbage. Normal RMW resumes from the second frame.
- Undefined: RMW is used from the first pixel.

Test Plan:
- Bench parameters: H_RES=4, V_RES=2, RD_LAT=1, memory model preloaded 9'h1FF.
- Pixel 3'd5 with sof at reset release -> READ addr 0, then WRITE addr 0 with data 9'b101_111_111; 4 cycles between accepts.
- Stream 8 pixels -> frame_done pulses once, frame_chunk_counter 0->0 (frame 0 done), wr_chunk=1. Next frame pixel 3'd2 at addr 0 writes 9'b101_010_111.
- Three full frames -> frame_chunk_counter sequence 0,1,2, wraps wr_chunk to 0; fourth frame overwrites [8:6] only.
- sof asserted at pixel 5 -> frame_drop pulse, address restarts at 0, frame_chunk_counter unchanged, no frame_done.
- reset_n dropped during WAIT -> mem_wr_en never asserts for that pixel; all outputs at reset values.
- With FHW_FIRST_FILL_EN: first-frame pixel 3'd3 -> no mem_rd_en, write 9'b011_011_011; second frame uses RMW.
